sdram_arbiter: RTL

Shares the single SDRAM controller request port in the Pocket core between several independent requesters: the bridge ROM download writer and the game-side ROM readers (program, tile, sprite, sound). It grants the port to one requester at a time using round-robin priority and tracks the one outstanding transaction. It returns the write acknowledge or read data to the owning requester. It sits inside `Main`, between the requester logic and the SDRAM controller, in the `clock` domain.

---
 rtl/sdram_arbiter_if.sv | 36 +++
 rtl/sdram_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester/controller bus shared through sdram_arbiter
interface sdram_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
);
  // requester side
  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            wr;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] din;
  logic [NUM_PORTS-1:0]            ack;
  logic [NUM_PORTS-1:0]            valid;
  logic [DATA_WIDTH-1:0]           dout;

  // SDRAM controller side
  logic                            ctrl_req;
  logic                            ctrl_wr;
  logic [ADDR_WIDTH-1:0]           ctrl_addr;
  logic [DATA_WIDTH-1:0]           ctrl_din;
  logic                            ctrl_ack;
  logic                            ctrl_valid;
  logic [DATA_WIDTH-1:0]           ctrl_dout;

  // arbiter view
  modport slave (
    input  req, wr, addr, din, ctrl_ack, ctrl_valid, ctrl_dout,
    output ack, valid, dout, ctrl_req, ctrl_wr, ctrl_addr, ctrl_din
  );

  // requesters plus controller view
  modport master (
    output req, wr, addr, din, ctrl_ack, ctrl_valid, ctrl_dout,
    input  ack, valid, dout, ctrl_req, ctrl_wr, ctrl_addr, ctrl_din
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter sharing one SDRAM controller port
module sdram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  sdram_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_READ_WAIT
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      last_q;
  logic                  ctrl_req_q;
  logic                  ctrl_wr_q;
  logic [ADDR_WIDTH-1:0] ctrl_addr_q;
  logic [DATA_WIDTH-1:0] ctrl_din_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [NUM_PORTS-1:0]  ack_q;
  logic [NUM_PORTS-1:0]  valid_q;

  logic [NUM_PORTS-1:0]  eligible;
  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  // Round-robin search: first eligible port after the last winner, wrapping;
  // the port being acked this cycle is masked so its held req is not re-granted.
  always_comb begin
    int cand;
    eligible = bus.req & ~ack_q;
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = (int'(last_q) + i) % NUM_PORTS;
      if (!found && eligible[IDX_W'(cand)]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

  // Select the winning port's direction, address and write data.
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_wr   = bus.wr[i];
        sel_addr = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: one outstanding transaction, no timeout.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ctrl_ack) begin
          state_next = ctrl_wr_q ? S_IDLE : S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (bus.ctrl_valid) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs: latch the grant, drive the controller, route ack/data back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q     <= '0;
      last_q      <= LAST_PORT;
      ctrl_req_q  <= 1'b0;
      ctrl_wr_q   <= 1'b0;
      ctrl_addr_q <= '0;
      ctrl_din_q  <= '0;
      dout_q      <= '0;
      ack_q       <= '0;
      valid_q     <= '0;
    end else begin
      ack_q   <= '0;
      valid_q <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_q     <= winner;
            last_q      <= winner;
            ctrl_req_q  <= 1'b1;
            ctrl_wr_q   <= sel_wr;
            ctrl_addr_q <= sel_addr;
            ctrl_din_q  <= sel_din;
          end
        end
        S_REQ: begin
          if (bus.ctrl_ack) begin
            ctrl_req_q     <= 1'b0;
            ack_q[grant_q] <= 1'b1;
          end
        end
        S_READ_WAIT: begin
          if (bus.ctrl_valid) begin
            dout_q           <= bus.ctrl_dout;
            valid_q[grant_q] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.valid     = valid_q;
  assign bus.dout      = dout_q;
  assign bus.ctrl_req  = ctrl_req_q;
  assign bus.ctrl_wr   = ctrl_wr_q;
  assign bus.ctrl_addr = ctrl_addr_q;
  assign bus.ctrl_din  = ctrl_din_q;

endmodule
